mem_stage: RTL and testbench

- Memory-access stage of the five-stage in-order pipeline. Sits between EX and WB.
- Takes the EX payload, which includes the load/store request already issued to synchronous data SRAM in EX. Selects and extends the load data returned by the SRAM, then forms the final register-file write.
- Presents the result to WB through the valid/allow_in handshake and drives the MEM-stage forwarding bus back to ID.

---
 rtl/mem_stage.sv | 141 ++++++++++++++
 tb/tb_mem_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: load data select/extend, write-back formation, forwarding
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   ex_to_mem_valid / mem_allow_in  EX -> MEM handshake
//   ex_*                            EX payload (pc, alu result/address, load op, rf write, store info)
//   data_sram_rdata                 synchronous SRAM read data, valid in the load's first MEM cycle
//   wb_allow_in / mem_to_wb_valid   MEM -> WB handshake
//   mem_pc, mem_sram_*              latched payload passed through to WB
//   mem_rf_we/waddr/wdata           final register-file write
//   mem_fwd_we/waddr/wdata          forwarding bus back to ID
//   mem_ale                         misaligned load detected
//   mem_valid                       stage occupancy
module mem_stage #(
  parameter int ALIGN_CHECK = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_to_mem_valid,
  output logic        mem_allow_in,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_result,
  input  logic [2:0]  ex_ld_op,
  input  logic [3:0]  ex_rf_we,
  input  logic [4:0]  ex_rf_waddr,
  input  logic [3:0]  ex_sram_we,
  input  logic [31:0] ex_sram_wdata,
  input  logic [31:0] data_sram_rdata,
  input  logic        wb_allow_in,
  output logic        mem_to_wb_valid,
  output logic [31:0] mem_pc,
  output logic [3:0]  mem_sram_we,
  output logic [31:0] mem_sram_wdata,
  output logic [31:0] mem_sram_addr,
  output logic [3:0]  mem_rf_we,
  output logic [4:0]  mem_rf_waddr,
  output logic [31:0] mem_rf_wdata,
  output logic        mem_fwd_we,
  output logic [4:0]  mem_fwd_waddr,
  output logic [31:0] mem_fwd_wdata,
  output logic        mem_ale,
  output logic        mem_valid
);

  localparam logic [2:0] LD_B  = 3'b001;
  localparam logic [2:0] LD_H  = 3'b010;
  localparam logic [2:0] LD_W  = 3'b011;
  localparam logic [2:0] LD_BU = 3'b101;
  localparam logic [2:0] LD_HU = 3'b110;

  logic        ready_go;
  logic        align_en;
  logic [31:0] mem_result;
  logic [2:0]  mem_ld_op;
  logic [3:0]  mem_rf_we_raw;
  logic        rdata_held;
  logic [31:0] rdata_hold;
  logic [31:0] rdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ready_go        = 1'b1;
  assign align_en        = (ALIGN_CHECK != 0);
  assign mem_allow_in    = !mem_valid || (ready_go && wb_allow_in);
  assign mem_to_wb_valid = mem_valid && ready_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid      <= 1'b0;
      mem_pc         <= '0;
      mem_result     <= '0;
      mem_ld_op      <= '0;
      mem_rf_we_raw  <= '0;
      mem_rf_waddr   <= '0;
      mem_sram_we    <= '0;
      mem_sram_wdata <= '0;
      rdata_held     <= 1'b0;
      rdata_hold     <= '0;
    end else begin
      if (mem_allow_in) begin
        mem_valid <= ex_to_mem_valid;
      end
      if (mem_allow_in && ex_to_mem_valid) begin
        mem_pc         <= ex_pc;
        mem_result     <= ex_result;
        mem_ld_op      <= ex_ld_op;
        mem_rf_we_raw  <= ex_rf_we;
        mem_rf_waddr   <= ex_rf_waddr;
        mem_sram_we    <= ex_sram_we;
        mem_sram_wdata <= ex_sram_wdata;
      end
      // The SRAM only presents the load data for one cycle; capture it so a
      // stalled load keeps returning the same value.
      if (mem_valid && !rdata_held) begin
        rdata_hold <= data_sram_rdata;
      end
      if (mem_allow_in) begin
        rdata_held <= 1'b0;
      end else if (mem_valid) begin
        rdata_held <= 1'b1;
      end
    end
  end

  assign rdata = rdata_held ? rdata_hold : data_sram_rdata;

  always_comb begin
    ld_byte = rdata[7:0];
    case (mem_result[1:0])
      2'd0: ld_byte = rdata[7:0];
      2'd1: ld_byte = rdata[15:8];
      2'd2: ld_byte = rdata[23:16];
      2'd3: ld_byte = rdata[31:24];
      default: ld_byte = rdata[7:0];
    endcase
    ld_half = mem_result[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    mem_rf_wdata = mem_result;
    case (mem_ld_op)
      LD_B:    mem_rf_wdata = {{24{ld_byte[7]}}, ld_byte};
      LD_BU:   mem_rf_wdata = {24'd0, ld_byte};
      LD_H:    mem_rf_wdata = {{16{ld_half[15]}}, ld_half};
      LD_HU:   mem_rf_wdata = {16'd0, ld_half};
      LD_W:    mem_rf_wdata = rdata;
      default: mem_rf_wdata = mem_result;
    endcase
  end

  assign mem_ale = align_en && mem_valid &&
                   ((((mem_ld_op == LD_H) || (mem_ld_op == LD_HU)) && mem_result[0]) ||
                    ((mem_ld_op == LD_W) && (mem_result[1:0] != 2'b00)));

  assign mem_rf_we     = (mem_valid && !mem_ale) ? mem_rf_we_raw : 4'b0000;
  assign mem_sram_addr = mem_result;
  assign mem_fwd_we    = |mem_rf_we;
  assign mem_fwd_waddr = mem_rf_waddr;
  assign mem_fwd_wdata = mem_rf_wdata;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed scoreboard bench for mem_stage (both ALIGN_CHECK settings)
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_to_mem_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_result;
  logic [2:0]  ex_ld_op;
  logic [3:0]  ex_rf_we;
  logic [4:0]  ex_rf_waddr;
  logic [3:0]  ex_sram_we;
  logic [31:0] ex_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        wb_allow_in;

  logic        a_allow_in, a_to_wb_valid, a_fwd_we, a_ale, a_valid;
  logic [31:0] a_pc, a_sram_wdata, a_sram_addr, a_rf_wdata, a_fwd_wdata;
  logic [3:0]  a_sram_we, a_rf_we;
  logic [4:0]  a_rf_waddr, a_fwd_waddr;

  logic        n_allow_in, n_to_wb_valid, n_fwd_we, n_ale, n_valid;
  logic [31:0] n_pc, n_sram_wdata, n_sram_addr, n_rf_wdata, n_fwd_wdata;
  logic [3:0]  n_sram_we, n_rf_we;
  logic [4:0]  n_rf_waddr, n_fwd_waddr;

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  rf_we;
    logic        ale;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_stage #(.ALIGN_CHECK(1)) u_dut_a (
    .clk(clk), .reset(reset),
    .ex_to_mem_valid(ex_to_mem_valid), .mem_allow_in(a_allow_in),
    .ex_pc(ex_pc), .ex_result(ex_result), .ex_ld_op(ex_ld_op),
    .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
    .ex_sram_we(ex_sram_we), .ex_sram_wdata(ex_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .wb_allow_in(wb_allow_in),
    .mem_to_wb_valid(a_to_wb_valid), .mem_pc(a_pc),
    .mem_sram_we(a_sram_we), .mem_sram_wdata(a_sram_wdata), .mem_sram_addr(a_sram_addr),
    .mem_rf_we(a_rf_we), .mem_rf_waddr(a_rf_waddr), .mem_rf_wdata(a_rf_wdata),
    .mem_fwd_we(a_fwd_we), .mem_fwd_waddr(a_fwd_waddr), .mem_fwd_wdata(a_fwd_wdata),
    .mem_ale(a_ale), .mem_valid(a_valid)
  );

  mem_stage #(.ALIGN_CHECK(0)) u_dut_n (
    .clk(clk), .reset(reset),
    .ex_to_mem_valid(ex_to_mem_valid), .mem_allow_in(n_allow_in),
    .ex_pc(ex_pc), .ex_result(ex_result), .ex_ld_op(ex_ld_op),
    .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
    .ex_sram_we(ex_sram_we), .ex_sram_wdata(ex_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .wb_allow_in(wb_allow_in),
    .mem_to_wb_valid(n_to_wb_valid), .mem_pc(n_pc),
    .mem_sram_we(n_sram_we), .mem_sram_wdata(n_sram_wdata), .mem_sram_addr(n_sram_addr),
    .mem_rf_we(n_rf_we), .mem_rf_waddr(n_rf_waddr), .mem_rf_wdata(n_rf_wdata),
    .mem_fwd_we(n_fwd_we), .mem_fwd_waddr(n_fwd_waddr), .mem_fwd_wdata(n_fwd_wdata),
    .mem_ale(n_ale), .mem_valid(n_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] res,
                       input logic [2:0] op, input logic [3:0] we, input logic [4:0] wa,
                       input logic [3:0] swe, input logic [31:0] swd);
    ex_to_mem_valid = v;
    ex_pc           = pc;
    ex_result       = res;
    ex_ld_op        = op;
    ex_rf_we        = we;
    ex_rf_waddr     = wa;
    ex_sram_we      = swe;
    ex_sram_wdata   = swd;
  endtask

  task automatic sb_push(input logic [4:0] wa, input logic [31:0] wd,
                         input logic [3:0] we, input logic ale);
    exp_t e;
    e.waddr = wa;
    e.wdata = wd;
    e.rf_we = we;
    e.ale   = ale;
    sb.push_back(e);
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_to_wb_valid"}, {31'd0, a_to_wb_valid}, 32'd1);
      chk({tag, "_waddr"}, {27'd0, a_fwd_waddr}, {27'd0, e.waddr});
      chk({tag, "_wdata"}, a_rf_wdata, e.wdata);
      chk({tag, "_fwd_wdata"}, a_fwd_wdata, e.wdata);
      chk({tag, "_rf_we"}, {28'd0, a_rf_we}, {28'd0, e.rf_we});
      chk({tag, "_ale"}, {31'd0, a_ale}, {31'd0, e.ale});
    end
  endtask

  initial begin
    reset = 1'b1;
    wb_allow_in = 1'b1;
    data_sram_rdata = 32'h0;
    drive(1'b0, 32'h0, 32'h0, 3'b000, 4'h0, 5'd0, 4'h0, 32'h0);
    tick();
    tick();
    chk("rst_valid", {31'd0, a_valid}, 32'd0);
    chk("rst_to_wb", {31'd0, a_to_wb_valid}, 32'd0);
    chk("rst_rf_we", {28'd0, a_rf_we}, 32'd0);
    chk("rst_fwd_we", {31'd0, a_fwd_we}, 32'd0);
    chk("rst_ale", {31'd0, a_ale}, 32'd0);
    chk("rst_allow_in", {31'd0, a_allow_in}, 32'd1);
    chk("rst_pc", a_pc, 32'd0);
    reset = 1'b0;

    // Load extraction, back-to-back, rdata 0x80AA55CC
    drive(1'b1, 32'h100, 32'h1003, 3'b001, 4'hf, 5'd5, 4'h0, 32'h0);
    sb_push(5'd5, 32'hFFFFFF80, 4'hf, 1'b0);
    tick();
    data_sram_rdata = 32'h80AA55CC;
    #1;
    sb_check("ld_b");
    drive(1'b1, 32'h104, 32'h1003, 3'b101, 4'hf, 5'd6, 4'h0, 32'h0);
    sb_push(5'd6, 32'h00000080, 4'hf, 1'b0);
    tick();
    #1;
    sb_check("ld_bu");
    drive(1'b1, 32'h108, 32'h1002, 3'b110, 4'hf, 5'd7, 4'h0, 32'h0);
    sb_push(5'd7, 32'h000080AA, 4'hf, 1'b0);
    tick();
    #1;
    sb_check("ld_hu");
    drive(1'b1, 32'h10C, 32'h1002, 3'b010, 4'hf, 5'd8, 4'h0, 32'h0);
    sb_push(5'd8, 32'hFFFF80AA, 4'hf, 1'b0);
    tick();
    #1;
    sb_check("ld_h");

    // Back-to-back add then ld.w, no bubble
    drive(1'b1, 32'h110, 32'h5, 3'b000, 4'hf, 5'd4, 4'b0011, 32'hCAFEF00D);
    sb_push(5'd4, 32'h5, 4'hf, 1'b0);
    tick();
    #1;
    sb_check("add");
    chk("add_fwd_we", {31'd0, a_fwd_we}, 32'd1);
    chk("add_sram_we", {28'd0, a_sram_we}, 32'h3);
    chk("add_sram_wdata", a_sram_wdata, 32'hCAFEF00D);
    drive(1'b1, 32'h114, 32'h1000, 3'b011, 4'hf, 5'd10, 4'h0, 32'h0);
    sb_push(5'd10, 32'h9, 4'hf, 1'b0);
    tick();
    data_sram_rdata = 32'h9;
    #1;
    sb_check("ldw_b2b");
    chk("ldw_b2b_pc", a_pc, 32'h114);
    chk("ldw_b2b_valid", {31'd0, a_valid}, 32'd1);

    // Misaligned ld.w
    drive(1'b1, 32'h118, 32'h1002, 3'b011, 4'hf, 5'd11, 4'h0, 32'h0);
    sb_push(5'd11, 32'h11223344, 4'h0, 1'b1);
    tick();
    data_sram_rdata = 32'h11223344;
    #1;
    sb_check("ale");
    chk("ale_fwd_we", {31'd0, a_fwd_we}, 32'd0);
    chk("noale_ale", {31'd0, n_ale}, 32'd0);
    chk("noale_rf_we", {28'd0, n_rf_we}, 32'hF);
    chk("noale_fwd_we", {31'd0, n_fwd_we}, 32'd1);
    chk("noale_wdata", n_rf_wdata, 32'h11223344);

    // Bubble: payload registers hold
    drive(1'b0, 32'h999, 32'h777, 3'b011, 4'hf, 5'd12, 4'hf, 32'h55);
    tick();
    #1;
    chk("bub_valid", {31'd0, a_valid}, 32'd0);
    chk("bub_rf_we", {28'd0, a_rf_we}, 32'd0);
    chk("bub_to_wb", {31'd0, a_to_wb_valid}, 32'd0);
    chk("bub_ale", {31'd0, a_ale}, 32'd0);
    chk("bub_pc", a_pc, 32'h118);
    chk("bub_addr", a_sram_addr, 32'h1002);
    chk("bub_waddr", {27'd0, a_rf_waddr}, 32'd11);

    // Stall hold: rdata changes while WB blocks
    wb_allow_in = 1'b0;
    drive(1'b1, 32'h120, 32'h2000, 3'b011, 4'hf, 5'd13, 4'h0, 32'h0);
    sb_push(5'd13, 32'h12345678, 4'hf, 1'b0);
    tick();
    data_sram_rdata = 32'h12345678;
    #1;
    chk("stall0_wdata", a_rf_wdata, sb[0].wdata);
    chk("stall0_allow_in", {31'd0, a_allow_in}, 32'd0);
    drive(1'b1, 32'h124, 32'h3000, 3'b000, 4'hf, 5'd14, 4'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      data_sram_rdata = 32'hDEADBEEF;
      #1;
      chk("stall_wdata", a_rf_wdata, sb[0].wdata);
      chk("stall_allow_in", {31'd0, a_allow_in}, 32'd0);
      chk("stall_to_wb", {31'd0, a_to_wb_valid}, 32'd1);
      chk("stall_pc", a_pc, 32'h120);
    end
    drive(1'b0, 32'h0, 32'h0, 3'b000, 4'h0, 5'd0, 4'h0, 32'h0);
    wb_allow_in = 1'b1;
    #1;
    chk("release_allow_in", {31'd0, a_allow_in}, 32'd1);
    sb_check("stall_done");
    tick();
    #1;
    chk("drain_valid", {31'd0, a_valid}, 32'd0);

    // Reset while a load is stalled
    wb_allow_in = 1'b0;
    drive(1'b1, 32'h130, 32'h1000, 3'b011, 4'hf, 5'd15, 4'h0, 32'h0);
    tick();
    data_sram_rdata = 32'h55;
    #1;
    drive(1'b0, 32'h0, 32'h0, 3'b000, 4'h0, 5'd0, 4'h0, 32'h0);
    tick();
    chk("pre_rst_valid", {31'd0, a_valid}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, a_valid}, 32'd0);
    chk("midrst_rf_we", {28'd0, a_rf_we}, 32'd0);
    chk("midrst_allow_in", {31'd0, a_allow_in}, 32'd1);
    chk("midrst_to_wb", {31'd0, a_to_wb_valid}, 32'd0);
    wb_allow_in = 1'b1;

    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
